pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the RV32 core. It merges jump requests from the execute stage and the interrupt controller with hold requests from execute, the bus arbiter and the JTAG debug module. From these it drives the single `jump_flag`/`jump_addr`/`hold_flag` set consumed by the PC register and the IF/ID/EX pipeline registers. It also sequences a post-reset boot hold, a debug halt handshake, and a bus-stall timeout monitor.

---
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Control-flow bundle between the jump/hold sources and pipe_ctrl.
// The master side drives the requests; the slave side is the controller.
interface pipe_ctrl_if;
    logic        ex_jump_flag_i;
    logic [31:0] ex_jump_addr_i;
    logic        ex_hold_flag_i;
    logic        int_jump_flag_i;
    logic [31:0] int_jump_addr_i;
    logic        int_hold_flag_i;
    logic        rib_hold_flag_i;
    logic        jtag_halt_req_i;
    logic        jtag_halt_ack_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_flag_o;
    logic        hold_timeout_o;

    modport slave (
        input  ex_jump_flag_i, ex_jump_addr_i, ex_hold_flag_i,
        input  int_jump_flag_i, int_jump_addr_i, int_hold_flag_i,
        input  rib_hold_flag_i, jtag_halt_req_i,
        output jtag_halt_ack_o, jump_flag_o, jump_addr_o, hold_flag_o, hold_timeout_o
    );

    modport master (
        output ex_jump_flag_i, ex_jump_addr_i, ex_hold_flag_i,
        output int_jump_flag_i, int_jump_addr_i, int_hold_flag_i,
        output rib_hold_flag_i, jtag_halt_req_i,
        input  jtag_halt_ack_o, jump_flag_o, jump_addr_o, hold_flag_o, hold_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges jump/hold requests, sequences boot hold,
// debug halt handshake and a bus-stall timeout monitor.
module pipe_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  pif
);

    typedef enum logic [2:0] {
        ST_BOOT, ST_RUN, ST_DRAIN, ST_HALTED, ST_RESUME
    } state_e;

    localparam int             BW        = $clog2(BOOT_CYCLES + 2);
    localparam logic [BW-1:0]  BOOT_LAST = BW'(BOOT_CYCLES);
    localparam logic [9:0]     STALL_MAX = 10'(TIMEOUT);
    localparam logic [2:0]     HOLD_NONE = 3'd0;
    localparam logic [2:0]     HOLD_PC   = 3'd1;
    localparam logic [2:0]     HOLD_ID   = 3'd3;

    state_e        state_q, state_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    logic [9:0]    stall_cnt_q, stall_cnt_d;
    logic          ack_q, ack_d;
    logic          timeout_q, timeout_d;

    logic          any_jump;
    logic          pipe_busy;
    logic [31:0]   jump_addr;
    logic          jump_flag;
    logic [2:0]    hold_flag;

    assign any_jump  = pif.int_jump_flag_i | pif.ex_jump_flag_i;
    assign pipe_busy = any_jump | pif.ex_hold_flag_i | pif.int_hold_flag_i | pif.rib_hold_flag_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= '0;
            stall_cnt_q <= '0;
            ack_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            ack_q       <= ack_d;
            timeout_q   <= timeout_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        unique case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q + 1'b1;
                if (boot_cnt_d >= BOOT_LAST) state_d = ST_RUN;
            end
            ST_RUN:    if (pif.jtag_halt_req_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!pif.jtag_halt_req_i) state_d = ST_RUN;
                else if (!pipe_busy)      state_d = ST_HALTED;
            end
            ST_HALTED: if (!pif.jtag_halt_req_i) state_d = ST_RESUME;
            ST_RESUME: state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
        // Ack is asserted only after a full cycle in HALTED and drops on the edge into RESUME.
        ack_d = (state_q == ST_HALTED) && pif.jtag_halt_req_i;
    end

    always_comb begin
        stall_cnt_d = '0;
        timeout_d   = timeout_q;
        if (pif.rib_hold_flag_i) begin
            if (stall_cnt_q == STALL_MAX) begin
                stall_cnt_d = stall_cnt_q;
                timeout_d   = 1'b1;
            end else begin
                stall_cnt_d = stall_cnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        jump_flag = 1'b0;
        jump_addr = '0;
        hold_flag = HOLD_NONE;
        unique case (state_q)
            ST_RUN: begin
                jump_flag = any_jump;
                jump_addr = pif.int_jump_flag_i ? pif.int_jump_addr_i :
                            pif.ex_jump_flag_i  ? pif.ex_jump_addr_i  : 32'h0;
                if (any_jump || pif.ex_hold_flag_i || pif.int_hold_flag_i) hold_flag = HOLD_ID;
                else if (pif.rib_hold_flag_i)                               hold_flag = HOLD_PC;
            end
            ST_DRAIN: begin
                // Pending control flow still completes while fetch is frozen.
                jump_flag = any_jump;
                jump_addr = pif.int_jump_flag_i ? pif.int_jump_addr_i :
                            pif.ex_jump_flag_i  ? pif.ex_jump_addr_i  : 32'h0;
                hold_flag = HOLD_PC;
            end
            ST_HALTED: hold_flag = HOLD_ID;
            default:   hold_flag = HOLD_PC;
        endcase
    end

    assign pif.jump_flag_o     = jump_flag;
    assign pif.jump_addr_o     = jump_addr;
    assign pif.hold_flag_o     = hold_flag;
    assign pif.jtag_halt_ack_o = ack_q;
    assign pif.hold_timeout_o  = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (BOOT_CYCLES = 4, TIMEOUT = 8): each stimulus cycle
// queues its expected outputs, a negedge monitor pops and compares them.
module tb_pipe_ctrl;

    typedef struct {
        string       tag;
        logic        jf;
        logic [31:0] ja;
        logic [2:0]  hf;
        logic        ack;
        logic        to;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];
    exp_t mon_e;

    pipe_ctrl_if pif();

    pipe_ctrl #(.BOOT_CYCLES(4), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, ".jump_flag"}, 32'(pif.jump_flag_o),     32'(mon_e.jf));
            check({mon_e.tag, ".jump_addr"}, pif.jump_addr_o,          mon_e.ja);
            check({mon_e.tag, ".hold_flag"}, 32'(pif.hold_flag_o),     32'(mon_e.hf));
            check({mon_e.tag, ".ack"},       32'(pif.jtag_halt_ack_o), 32'(mon_e.ack));
            check({mon_e.tag, ".timeout"},   32'(pif.hold_timeout_o),  32'(mon_e.to));
        end
    end

    task automatic drive(input logic exj, input logic [31:0] exa, input logic exh,
                         input logic ij, input logic [31:0] ia, input logic ih,
                         input logic rib, input logic req);
        pif.ex_jump_flag_i  = exj;
        pif.ex_jump_addr_i  = exa;
        pif.ex_hold_flag_i  = exh;
        pif.int_jump_flag_i = ij;
        pif.int_jump_addr_i = ia;
        pif.int_hold_flag_i = ih;
        pif.rib_hold_flag_i = rib;
        pif.jtag_halt_req_i = req;
    endtask

    task automatic expect_out(input string tag, input logic jf, input logic [31:0] ja,
                              input logic [2:0] hf, input logic ack, input logic to);
        exp_t e;
        e.tag = tag; e.jf = jf; e.ja = ja; e.hf = hf; e.ack = ack; e.to = to;
        sb_q.push_back(e);
    endtask

    // One cycle: inputs applied just after the posedge, expectation for that cycle queued.
    task automatic step(input string tag,
                        input logic exj, input logic [31:0] exa, input logic exh,
                        input logic ij, input logic [31:0] ia, input logic ih,
                        input logic rib, input logic req,
                        input logic jf, input logic [31:0] ja, input logic [2:0] hf,
                        input logic ack, input logic to);
        @(posedge clk);
        #1;
        drive(exj, exa, exh, ij, ia, ih, rib, req);
        expect_out(tag, jf, ja, hf, ack, to);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("reset.hold_flag", 32'(pif.hold_flag_o),     32'd1);
        check("reset.jump_flag", 32'(pif.jump_flag_o),     32'd0);
        check("reset.jump_addr", pif.jump_addr_o,          32'd0);
        check("reset.ack",       32'(pif.jtag_halt_ack_o), 32'd0);
        check("reset.timeout",   32'(pif.hold_timeout_o),  32'd0);

        // Boot hold: exactly four cycles of hold 1, jumps masked.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_out("boot0", 0, 0, 1, 0, 0);
        //       tag        exj exa     exh ij ia      ih rib req  jf ja      hf ack to
        step("boot1",       0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      1, 0,  0);
        step("boot2_jmp",   1,  32'h100,0,  0, 0,      0, 0,  0,   0, 0,      1, 0,  0);
        step("boot3",       0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      1, 0,  0);
        step("run0",        0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      0, 0,  0);
        step("run1",        0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      0, 0,  0);

        // Jump arbitration and hold merging in RUN.
        step("ex_jump",     1,  32'h100,0,  0, 0,      0, 0,  0,   1, 32'h100,3, 0,  0);
        step("both_jump",   1,  32'h100,0,  1, 32'h200,0, 0,  0,   1, 32'h200,3, 0,  0);
        step("int_jump",    0,  0,      0,  1, 32'h200,0, 0,  0,   1, 32'h200,3, 0,  0);
        step("rib_ex_hold", 0,  0,      1,  0, 0,      0, 1,  0,   0, 0,      3, 0,  0);
        step("rib_hold",    0,  0,      0,  0, 0,      0, 1,  0,   0, 0,      1, 0,  0);
        step("int_hold",    0,  0,      0,  0, 0,      1, 0,  0,   0, 0,      3, 0,  0);
        step("no_hold",     0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      0, 0,  0);

        // Bus stall for 9 cycles: flag appears only after the 9th edge, then sticks.
        for (int k = 1; k <= 9; k++)
            step($sformatf("stall%0d", k), 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        step("stall_done0", 0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      0, 0,  1);
        step("stall_done1", 0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      0, 0,  1);

        // Halt with execute busy, a jump completing in DRAIN, then release.
        step("halt_req",    0,  0,      1,  0, 0,      0, 0,  1,   0, 0,      3, 0,  1);
        step("drain1",      0,  0,      1,  0, 0,      0, 0,  1,   0, 0,      1, 0,  1);
        step("drain2_jmp",  1,  32'h300,1,  0, 0,      0, 0,  1,   1, 32'h300,1, 0,  1);
        step("drain3_idle", 0,  0,      0,  0, 0,      0, 0,  1,   0, 0,      1, 0,  1);
        step("halted1",     0,  0,      0,  1, 32'h400,0, 0,  1,   0, 0,      3, 0,  1);
        step("halted2",     0,  0,      0,  1, 32'h400,0, 0,  1,   0, 0,      3, 1,  1);
        step("halted_drop", 0,  0,      0,  1, 32'h400,0, 0,  0,   0, 0,      3, 1,  1);
        step("resume",      0,  0,      0,  1, 32'h400,0, 0,  0,   0, 0,      1, 0,  1);
        step("run_int",     0,  0,      0,  1, 32'h400,0, 0,  0,   1, 32'h400,3, 0,  1);
        step("run_idle",    0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      0, 0,  1);

        // Halt request together with a jump, then request withdrawn in DRAIN.
        step("halt_jump",   1,  32'h500,0,  0, 0,      0, 0,  1,   1, 32'h500,3, 0,  1);
        step("drain_drop",  0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      1, 0,  1);
        step("back_run",    0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      0, 0,  1);

        // Minimum-latency halt, then reset while halted with an interrupt pending.
        step("req_idle",    0,  0,      0,  0, 0,      0, 0,  1,   0, 0,      0, 0,  1);
        step("drain_idle",  0,  0,      0,  0, 0,      0, 0,  1,   0, 0,      1, 0,  1);
        step("halt_a",      0,  0,      0,  1, 32'h600,0, 0,  1,   0, 0,      3, 0,  1);
        step("halt_b",      0,  0,      0,  1, 32'h600,0, 0,  1,   0, 0,      3, 1,  1);

        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst.ack",       32'(pif.jtag_halt_ack_o), 32'd0);
        check("async_rst.timeout",   32'(pif.hold_timeout_o),  32'd0);
        check("async_rst.hold_flag", 32'(pif.hold_flag_o),     32'd1);
        check("async_rst.jump_flag", 32'(pif.jump_flag_o),     32'd0);

        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 1, 32'h600, 0, 0, 0);
        expect_out("reboot0", 0, 0, 1, 0, 0);
        step("reboot1",     0,  0,      0,  1, 32'h600,0, 0,  0,   0, 0,      1, 0,  0);
        step("reboot2",     0,  0,      0,  1, 32'h600,0, 0,  0,   0, 0,      1, 0,  0);
        step("reboot3",     0,  0,      0,  1, 32'h600,0, 0,  0,   0, 0,      1, 0,  0);
        step("reboot_int",  0,  0,      0,  1, 32'h600,0, 0,  0,   1, 32'h600,3, 0,  0);
        step("final_idle",  0,  0,      0,  0, 0,      0, 0,  0,   0, 0,      0, 0,  0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
